spart_ctrl: RTL and testbench



---
 rtl/spart_pkg.sv | 33 +++
 rtl/spart_rr_arb.sv | 29 ++
 rtl/spart_ctrl.sv | 131 +++++++++++++
 tb/tb_spart_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART bus controller: FSM states,
// bus register addresses and the baud divisor table.
package spart_pkg;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    GAP,
    IDLE,
    WR,
    RD
  } state_t;

  typedef enum logic {
    GNT_TX = 1'b0,
    GNT_RX = 1'b1
  } grant_t;

  localparam logic [1:0] ADDR_DATA  = 2'b00;
  localparam logic [1:0] ADDR_STAT  = 2'b01;
  localparam logic [1:0] ADDR_DIVLO = 2'b10;
  localparam logic [1:0] ADDR_DIVHI = 2'b11;

  function automatic logic [15:0] br_divisor(input logic [1:0] cfg);
    case (cfg)
      2'b00:   br_divisor = 16'h0145;
      2'b01:   br_divisor = 16'h00A2;
      2'b10:   br_divisor = 16'h0051;
      default: br_divisor = 16'h0028;
    endcase
  endfunction

endpackage

// File: rtl/spart_rr_arb.sv
// Two-requester round-robin arbiter; grants are combinational, the
// last-granted side is remembered only when load is asserted.
module spart_rr_arb
  import spart_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_tx,
  input  logic   req_rx,
  input  logic   load,
  output logic   gnt_tx,
  output logic   gnt_rx,
  output grant_t last_grant
);

  always_comb begin
    gnt_tx = req_tx & (~req_rx | (last_grant == GNT_RX));
    gnt_rx = req_rx & (~req_tx | (last_grant == GNT_TX));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= GNT_RX;
    end else if (load) begin
      last_grant <= gnt_tx ? GNT_TX : GNT_RX;
    end
  end

endmodule

// File: rtl/spart_ctrl.sv
// SPART processor-bus sequencer: programs the baud divisor, then shares the
// bus between a transmit and a receive byte stream with round-robin arbitration.
module spart_ctrl
  import spart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  input  logic       rda,
  input  logic       tbr,
  inout  logic [7:0] databus
);

  state_t     state_q, state_d;
  logic       boot_q;
  logic [1:0] cfg_q, cfg_d;
  logic       cfg_chg;
  logic [7:0] drv_q, drv_d;
  logic       iocs_d, iorw_d;
  logic [1:0] ioaddr_d;
  logic       gnt_tx, gnt_rx, arb_load, tx_grant;
  grant_t     last_grant;

  spart_rr_arb u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_tx     (tx_valid & tbr),
    .req_rx     (rda & ~rx_valid),
    .load       (arb_load),
    .gnt_tx     (gnt_tx),
    .gnt_rx     (gnt_rx),
    .last_grant (last_grant)
  );

  // Bus registers are loaded from the decode of the next state, so a one-cycle
  // boot flag holds CFG_LO for the first post-reset edge to put it on the bus.
  always_comb begin
    state_d  = state_q;
    cfg_chg  = 1'b0;
    tx_grant = 1'b0;
    arb_load = 1'b0;
    drv_d    = drv_q;
    iocs_d   = 1'b0;
    iorw_d   = 1'b1;
    ioaddr_d = ADDR_DATA;
    case (state_q)
      CFG_LO: state_d = boot_q ? CFG_LO : CFG_HI;
      CFG_HI: state_d = GAP;
      GAP:    state_d = IDLE;
      IDLE: begin
        if (br_cfg != cfg_q) begin
          cfg_chg = 1'b1;
          state_d = CFG_LO;
        end else if (gnt_tx) begin
          tx_grant = 1'b1;
          arb_load = 1'b1;
          drv_d    = tx_data;
          state_d  = WR;
        end else if (gnt_rx) begin
          arb_load = 1'b1;
          state_d  = RD;
        end
      end
      WR:      state_d = GAP;
      RD:      state_d = GAP;
      default: state_d = CFG_LO;
    endcase
    cfg_d = cfg_chg ? br_cfg : cfg_q;
    case (state_d)
      CFG_LO: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = ADDR_DIVLO;
        drv_d    = br_divisor(cfg_d)[7:0];
      end
      CFG_HI: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = ADDR_DIVHI;
        drv_d    = br_divisor(cfg_d)[15:8];
      end
      WR: begin
        iocs_d = 1'b1;
        iorw_d = 1'b0;
      end
      RD:      iocs_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= CFG_LO;
      boot_q   <= 1'b1;
      cfg_q    <= br_cfg;
      drv_q    <= '0;
      iocs     <= 1'b0;
      iorw     <= 1'b1;
      ioaddr   <= ADDR_DATA;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      state_q <= state_d;
      boot_q  <= 1'b0;
      cfg_q   <= cfg_d;
      drv_q   <= drv_d;
      iocs    <= iocs_d;
      iorw    <= iorw_d;
      ioaddr  <= ioaddr_d;
      if (state_q == RD) begin
        rx_valid <= 1'b1;
        rx_data  <= databus;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign tx_ready = rst & tx_grant;
  assign databus  = (iocs && !iorw) ? drv_q : 'z;

endmodule

// File: tb/tb_spart_ctrl.sv
// Directed bench for spart_ctrl with a minimal SPART bus responder.
module tb_spart_ctrl;
  import spart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  logic       rda, tbr;
  logic [7:0] rd_byte;
  wire  [7:0] databus;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  // Responder: returns rd_byte on reads, parks the bus at 0x5A while deselected.
  assign databus = (iocs && iorw) ? rd_byte : (!iocs ? 8'h5A : 'z);

  spart_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .rda      (rda),
    .tbr      (tbr),
    .databus  (databus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus(input string tag, input logic cs, input logic rw,
                           input logic [1:0] addr, input logic [7:0] data);
    check({tag, ".iocs"}, 16'(iocs), 16'(cs));
    check({tag, ".iorw"}, 16'(iorw), 16'(rw));
    check({tag, ".ioaddr"}, 16'(ioaddr), 16'(addr));
    check({tag, ".data"}, 16'(databus), 16'(data));
  endtask

  logic       seen_rw [4];
  int unsigned n_ops;
  logic       exp_rw [4];

  initial begin
    rst = 1'b0; br_cfg = 2'b00; tx_valid = 1'b1; tx_data = 8'h00; tbr = 1'b1;
    rda = 1'b0; rx_ready = 1'b0; rd_byte = 8'h00;
    tick(); tick();
    check_bus("rst", 1'b0, 1'b1, 2'b00, 8'h5A);
    check("rst.tx_ready", 16'(tx_ready), 16'h0);
    check("rst.rx_valid", 16'(rx_valid), 16'h0);
    check("rst.rx_data", 16'(rx_data), 16'h0);
    tx_valid = 1'b0; tbr = 1'b0;

    rst = 1'b1;
    tick(); check_bus("boot.lo", 1'b1, 1'b0, 2'b10, 8'h45);
    tick(); check_bus("boot.hi", 1'b1, 1'b0, 2'b11, 8'h01);
    tick(); check("boot.gap.iocs", 16'(iocs), 16'h0);
    tick(); check("boot.idle.iocs", 16'(iocs), 16'h0);

    // single transmit
    tbr = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5;
    #1 check("tx.ready", 16'(tx_ready), 16'h1);
    tick(); tx_valid = 1'b0;
    check_bus("tx.wr", 1'b1, 1'b0, 2'b00, 8'hA5);
    check("tx.ready_wr", 16'(tx_ready), 16'h0);
    tick(); check("tx.gap.iocs", 16'(iocs), 16'h0);
    tick();

    // single receive, then stall while the byte is unconsumed
    rda = 1'b1; rd_byte = 8'h3C;
    tick(); check_bus("rx.rd", 1'b1, 1'b1, 2'b00, 8'h3C);
    check("rx.valid_in_rd", 16'(rx_valid), 16'h0);
    tick();
    check("rx.valid", 16'(rx_valid), 16'h1);
    check("rx.data", 16'(rx_data), 16'h3C);
    for (int i = 0; i < 4; i++) begin
      tick(); check("rx.stall.iocs", 16'(iocs), 16'h0);
    end
    rx_ready = 1'b1; rda = 1'b0;
    tick(); check("rx.consumed", 16'(rx_valid), 16'h0);
    check("rx.data_hold", 16'(rx_data), 16'h3C);
    rx_ready = 1'b0;

    // both clients busy: TX, RX, TX, RX
    exp_rw[0] = 1'b0; exp_rw[1] = 1'b1; exp_rw[2] = 1'b0; exp_rw[3] = 1'b1;
    tx_valid = 1'b1; tx_data = 8'h11; rda = 1'b1; rx_ready = 1'b1; rd_byte = 8'h22;
    n_ops = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (iocs && n_ops < 4) begin
        seen_rw[n_ops] = iorw;
        n_ops++;
      end
    end
    check("rr.count", 16'(n_ops), 16'd4);
    for (int i = 0; i < 4; i++)
      if (i < int'(n_ops)) check($sformatf("rr.grant%0d", i), 16'(seen_rw[i]), 16'(exp_rw[i]));
    tx_valid = 1'b0; rda = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rx_ready = 1'b0;

    // baud change during WR reprograms before any grant
    tx_valid = 1'b1; tx_data = 8'h77;
    #1 check("cfg.tx_ready", 16'(tx_ready), 16'h1);
    tick(); check_bus("cfg.wr", 1'b1, 1'b0, 2'b00, 8'h77);
    br_cfg = 2'b11;
    tick(); check("cfg.gap.iocs", 16'(iocs), 16'h0);
    tick(); check("cfg.idle.iocs", 16'(iocs), 16'h0);
    check("cfg.no_grant", 16'(tx_ready), 16'h0);
    tick(); check_bus("cfg.lo", 1'b1, 1'b0, 2'b10, 8'h28);
    check("cfg.lo.tx_ready", 16'(tx_ready), 16'h0);
    tick(); check_bus("cfg.hi", 1'b1, 1'b0, 2'b11, 8'h00);
    tick(); check("cfg.gap2.iocs", 16'(iocs), 16'h0);
    tick(); check("cfg.grant_after", 16'(tx_ready), 16'h1);
    tx_data = 8'hC3;

    // reset during WR aborts and reprograms
    tick(); check_bus("arst.wr", 1'b1, 1'b0, 2'b00, 8'hC3);
    tx_valid = 1'b0; rst = 1'b0;
    tick(); check_bus("arst.abort", 1'b0, 1'b1, 2'b00, 8'h5A);
    check("arst.tx_ready", 16'(tx_ready), 16'h0);
    rst = 1'b1;
    tick(); check_bus("arst.lo", 1'b1, 1'b0, 2'b10, 8'h28);
    tick(); check_bus("arst.hi", 1'b1, 1'b0, 2'b11, 8'h00);
    tick(); check("arst.gap.iocs", 16'(iocs), 16'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
